// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Fetch/decode/execute controller for the 4-bit accumulator datapath. It fetches
// opcode, operand and (for JCN/ISZ/JUN) two branch-target nibbles from a 4-bit
// program-memory port. It owns the program counter and resolves all branches.
// The datapath control strobes and selects are driven for exactly one EXEC cycle
// per instruction.
//
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   rom_req/rom_addr    nibble fetch request and address (address = pc)
//   rom_ack/rom_data    fetched nibble, valid while rom_ack is high
//   take_branch         datapath condition result used by JCN
//   reg_is_zero         datapath register-equals-zero flag used by ISZ
//   inst_operand        latched operand nibble (immediate / register index)
//   clear_*/write_*     datapath strobes, asserted only in EXEC
//   *_sel, alu_op       datapath selects, meaningful only in EXEC
//   dp_halt, halted     halt indications
//   step                single-step advance (only with the option below)
//
// Build option: define CPU_SEQUENCER_SINGLE_STEP_EN to add a WAIT_STEP state.
// The sequencer then parks after every instruction until it sees a rising edge on step.
module cpu_sequencer #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    output logic                rom_req,
    output logic [PC_WIDTH-1:0] rom_addr,
    input  logic                rom_ack,
    input  logic [3:0]          rom_data,
    input  logic                take_branch,
    input  logic                reg_is_zero,
    output logic [3:0]          inst_operand,
    output logic                dp_halt,
    output logic                clear_carry,
    output logic                write_carry,
    output logic                clear_accumulator,
    output logic                write_accumulator,
    output logic                write_register,
    output logic [2:0]          acc_input_sel,
    output logic [1:0]          reg_input_sel,
    output logic [2:0]          alu_op,
    output logic [2:0]          alu_in0_sel,
    output logic [1:0]          alu_in1_sel,
    output logic [1:0]          alu_cin_sel,
    output logic                halted,
    input  logic                step
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_JCN = 4'h1;
    localparam logic [3:0] OP_LDM = 4'h2;
    localparam logic [3:0] OP_LD  = 4'h3;
    localparam logic [3:0] OP_XCH = 4'h4;
    localparam logic [3:0] OP_ADD = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_INC = 4'h7;
    localparam logic [3:0] OP_ISZ = 4'h8;
    localparam logic [3:0] OP_JUN = 4'h9;
    localparam logic [3:0] OP_CLB = 4'hA;
    localparam logic [3:0] OP_CLC = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ACC_SEL_ALU = 3'd0;
    localparam logic [2:0] ACC_SEL_IMM = 3'd1;
    localparam logic [2:0] ACC_SEL_REG = 3'd2;
    localparam logic [1:0] REG_SEL_ALU = 2'd0;
    localparam logic [1:0] REG_SEL_ACC = 2'd1;
    localparam logic [2:0] ALU_OP_ADD  = 3'd0;
    localparam logic [2:0] ALU0_ACC    = 3'd0;
    localparam logic [2:0] ALU0_REG    = 3'd1;
    localparam logic [1:0] ALU1_REG    = 2'd0;
    localparam logic [1:0] ALU1_NREG   = 2'd1;
    localparam logic [1:0] ALU1_ZERO   = 2'd2;
    localparam logic [1:0] CIN_CARRY   = 2'd0;
    localparam logic [1:0] CIN_NCARRY  = 2'd1;
    localparam logic [1:0] CIN_ONE     = 2'd2;

`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    typedef enum logic [2:0] {
        FETCH_OP, FETCH_OPR, FETCH_AH, FETCH_AL, EXEC, ISZ_CHK, HALTED, WAIT_STEP
    } state_t;
    localparam state_t AFTER_EXEC = WAIT_STEP;
`else
    typedef enum logic [2:0] {
        FETCH_OP, FETCH_OPR, FETCH_AH, FETCH_AL, EXEC, ISZ_CHK, HALTED
    } state_t;
    localparam state_t AFTER_EXEC = FETCH_OP;
`endif

    typedef struct packed {
        logic       clear_carry;
        logic       write_carry;
        logic       clear_accumulator;
        logic       write_accumulator;
        logic       write_register;
        logic [2:0] acc_input_sel;
        logic [1:0] reg_input_sel;
        logic [2:0] alu_op;
        logic [2:0] alu_in0_sel;
        logic [1:0] alu_in1_sel;
        logic [1:0] alu_cin_sel;
    } ctrl_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [3:0]            opcode_q, opcode_d;
    logic [3:0]            operand_q, operand_d;
    logic [7:0]            target_q, target_d;
    ctrl_t                 ctrl_q, ctrl_d;
    ctrl_t                 ctrl_out;
    logic                  rom_req_q, rom_req_d;
    logic                  halted_q, halted_d;
    logic                  dp_halt_q, dp_halt_d;
    logic                  fetch_ack;
    logic                  needs_target;
    logic [PC_WIDTH-1:0]   target_ext;

`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    logic                  step_q;
    logic                  step_rise;
    assign step_rise = step & ~step_q;
`else
    logic                  unused_step;
    assign unused_step = step;
`endif

    // Translate an opcode into the strobe/select bundle the datapath needs for
    // its single EXEC cycle. Opcodes with no datapath effect return all zeros.
    function automatic ctrl_t decode_op(input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_LDM: begin
                c.write_accumulator = 1'b1;
                c.acc_input_sel     = ACC_SEL_IMM;
            end
            OP_LD: begin
                c.write_accumulator = 1'b1;
                c.acc_input_sel     = ACC_SEL_REG;
            end
            OP_XCH: begin
                c.write_accumulator = 1'b1;
                c.acc_input_sel     = ACC_SEL_REG;
                c.write_register    = 1'b1;
                c.reg_input_sel     = REG_SEL_ACC;
            end
            OP_ADD, OP_SUB: begin
                c.write_accumulator = 1'b1;
                c.write_carry       = 1'b1;
                c.acc_input_sel     = ACC_SEL_ALU;
                c.alu_op            = ALU_OP_ADD;
                c.alu_in0_sel       = ALU0_ACC;
                c.alu_in1_sel       = (op == OP_SUB) ? ALU1_NREG : ALU1_REG;
                c.alu_cin_sel       = (op == OP_SUB) ? CIN_NCARRY : CIN_CARRY;
            end
            OP_INC, OP_ISZ: begin
                c.write_register    = 1'b1;
                c.reg_input_sel     = REG_SEL_ALU;
                c.alu_op            = ALU_OP_ADD;
                c.alu_in0_sel       = ALU0_REG;
                c.alu_in1_sel       = ALU1_ZERO;
                c.alu_cin_sel       = CIN_ONE;
            end
            OP_CLB: begin
                c.clear_accumulator = 1'b1;
                c.clear_carry       = 1'b1;
            end
            OP_CLC: begin
                c.clear_carry       = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    // Only a request we are actually making can be acknowledged; a stray ack
    // outside the fetch states never moves the pc or the latches.
    assign fetch_ack    = rom_ack & rom_req_q;
    assign needs_target = (opcode_q == OP_JCN) || (opcode_q == OP_ISZ) || (opcode_q == OP_JUN);

    // The branch target is always 8 bits; zero-extend it to the pc width.
    always_comb begin
        target_ext      = '0;
        target_ext[7:0] = target_q;
    end

    // Next-state logic for the sequencer. Fetch states hold until acked, then
    // latch the nibble and bump the pc. EXEC and ISZ_CHK overwrite the pc with
    // the branch target when taken, which naturally overrides the pc+1 value.
    // The registered outputs are derived from the next state. That puts the
    // strobes in the same cycle as EXEC and keeps rom_req high for every fetch state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        target_d  = target_q;
        case (state_q)
            FETCH_OP: begin
                if (fetch_ack) begin
                    opcode_d = rom_data;
                    pc_d     = pc_q + PC_WIDTH'(1);
                    state_d  = FETCH_OPR;
                end
            end
            FETCH_OPR: begin
                if (fetch_ack) begin
                    operand_d = rom_data;
                    pc_d      = pc_q + PC_WIDTH'(1);
                    state_d   = needs_target ? FETCH_AH : EXEC;
                end
            end
            FETCH_AH: begin
                if (fetch_ack) begin
                    target_d[7:4] = rom_data;
                    pc_d          = pc_q + PC_WIDTH'(1);
                    state_d       = FETCH_AL;
                end
            end
            FETCH_AL: begin
                if (fetch_ack) begin
                    target_d[3:0] = rom_data;
                    pc_d          = pc_q + PC_WIDTH'(1);
                    state_d       = EXEC;
                end
            end
            EXEC: begin
                state_d = AFTER_EXEC;
                case (opcode_q)
                    OP_JCN: begin
                        if (take_branch) begin
                            pc_d = target_ext;
                        end
                    end
                    OP_JUN: pc_d = target_ext;
                    OP_ISZ: state_d = ISZ_CHK;
                    OP_HLT: state_d = HALTED;
                    default: state_d = AFTER_EXEC;
                endcase
            end
            ISZ_CHK: begin
                if (!reg_is_zero) begin
                    pc_d = target_ext;
                end
                state_d = AFTER_EXEC;
            end
            HALTED: begin
                state_d = HALTED;
            end
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
            WAIT_STEP: begin
                if (step_rise) begin
                    state_d = FETCH_OP;
                end
            end
`endif
            default: begin
                state_d = FETCH_OP;
            end
        endcase

        rom_req_d = (state_d == FETCH_OP) || (state_d == FETCH_OPR) ||
                    (state_d == FETCH_AH) || (state_d == FETCH_AL);
        ctrl_d    = (state_d == EXEC) ? decode_op(opcode_d) : '0;
        halted_d  = (state_d == HALTED);
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
        dp_halt_d = (state_d == HALTED) || (state_d == WAIT_STEP);
`else
        dp_halt_d = (state_d == HALTED);
`endif
    end

    // All sequencer state and registered outputs. rom_req_q resets high because
    // the reset state is FETCH_OP. The output gating below keeps the port low
    // while reset is actually asserted.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FETCH_OP;
            pc_q      <= RESET_PC;
            opcode_q  <= '0;
            operand_q <= '0;
            target_q  <= '0;
            ctrl_q    <= '0;
            rom_req_q <= 1'b1;
            halted_q  <= 1'b0;
            dp_halt_q <= 1'b0;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
            step_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            target_q  <= target_d;
            ctrl_q    <= ctrl_d;
            rom_req_q <= rom_req_d;
            halted_q  <= halted_d;
            dp_halt_q <= dp_halt_d;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
            step_q    <= step;
`endif
        end
    end

    // Reset overrides the strobes and the fetch request in the same cycle it is
    // raised. A reset landing on EXEC therefore never produces a partial write.
    assign ctrl_out          = reset ? '0 : ctrl_q;
    assign rom_req           = rom_req_q & ~reset;
    assign rom_addr          = pc_q;
    assign inst_operand      = operand_q;
    assign halted            = halted_q;
    assign dp_halt           = dp_halt_q;
    assign clear_carry       = ctrl_out.clear_carry;
    assign write_carry       = ctrl_out.write_carry;
    assign clear_accumulator = ctrl_out.clear_accumulator;
    assign write_accumulator = ctrl_out.write_accumulator;
    assign write_register    = ctrl_out.write_register;
    assign acc_input_sel     = ctrl_out.acc_input_sel;
    assign reg_input_sel     = ctrl_out.reg_input_sel;
    assign alu_op            = ctrl_out.alu_op;
    assign alu_in0_sel       = ctrl_out.alu_in0_sel;
    assign alu_in1_sel       = ctrl_out.alu_in1_sel;
    assign alu_cin_sel       = ctrl_out.alu_cin_sel;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
// Directed bench for cpu_sequencer. A small ROM responder answers fetches with a
// programmable ack delay and logs every acknowledged address. It also logs the
// control vector of every cycle that carries a strobe. The main sequence runs
// short programs and compares against hand-derived results.
module tb_cpu_sequencer;

    localparam logic [2:0] ACC_SEL_ALU = 3'd0;
    localparam logic [2:0] ACC_SEL_IMM = 3'd1;
    localparam logic [2:0] ACC_SEL_REG = 3'd2;
    localparam logic [1:0] REG_SEL_ALU = 2'd0;
    localparam logic [1:0] REG_SEL_ACC = 2'd1;
    localparam logic [2:0] ALU_OP_ADD  = 3'd0;
    localparam logic [2:0] ALU0_ACC    = 3'd0;
    localparam logic [2:0] ALU0_REG    = 3'd1;
    localparam logic [1:0] ALU1_REG    = 2'd0;
    localparam logic [1:0] ALU1_NREG   = 2'd1;
    localparam logic [1:0] ALU1_ZERO   = 2'd2;
    localparam logic [1:0] CIN_CARRY   = 2'd0;
    localparam logic [1:0] CIN_NCARRY  = 2'd1;
    localparam logic [1:0] CIN_ONE     = 2'd2;

    logic       clock;
    logic       reset;
    logic       rom_req;
    logic [7:0] rom_addr;
    logic       rom_ack;
    logic [3:0] rom_data;
    logic       take_branch;
    logic       reg_is_zero;
    logic [3:0] inst_operand;
    logic       dp_halt;
    logic       clear_carry;
    logic       write_carry;
    logic       clear_accumulator;
    logic       write_accumulator;
    logic       write_register;
    logic [2:0] acc_input_sel;
    logic [1:0] reg_input_sel;
    logic [2:0] alu_op;
    logic [2:0] alu_in0_sel;
    logic [1:0] alu_in1_sel;
    logic [1:0] alu_cin_sel;
    logic       halted;
    logic       step;

    int          checks = 0;
    int          failures = 0;

    logic [3:0]  mem [256];
    logic [7:0]  acked [$];
    logic [19:0] exec_log [$];
    logic [19:0] exp_log [7];
    logic [19:0] ctrl_now;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          stable_err = 0;
    int          wr_acc_cnt = 0;
    int          wr_reg_cnt = 0;
    int          strobe_cnt = 0;
    logic [7:0]  hold_addr = 8'h00;
    logic [3:0]  last_operand = 4'h0;
    logic        auto_step = 1'b1;
    logic        manual_step = 1'b0;

    cpu_sequencer dut (
        .clock             (clock),
        .reset             (reset),
        .rom_req           (rom_req),
        .rom_addr          (rom_addr),
        .rom_ack           (rom_ack),
        .rom_data          (rom_data),
        .take_branch       (take_branch),
        .reg_is_zero       (reg_is_zero),
        .inst_operand      (inst_operand),
        .dp_halt           (dp_halt),
        .clear_carry       (clear_carry),
        .write_carry       (write_carry),
        .clear_accumulator (clear_accumulator),
        .write_accumulator (write_accumulator),
        .write_register    (write_register),
        .acc_input_sel     (acc_input_sel),
        .reg_input_sel     (reg_input_sel),
        .alu_op            (alu_op),
        .alu_in0_sel       (alu_in0_sel),
        .alu_in1_sel       (alu_in1_sel),
        .alu_cin_sel       (alu_cin_sel),
        .halted            (halted),
        .step              (step)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Global time limit so a stuck design can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // ROM responder and strobe monitor, acting 1 ns after each falling edge.
    // Acks come ack_delay cycles after a request appears. Stray acks with
    // junk data are driven whenever no request is pending, so any latch on
    // an unrequested ack shows up in the results. step either toggles on its own
    // (so single-step builds keep running) or follows manual_step.
    initial begin
        rom_ack  = 1'b0;
        rom_data = 4'h0;
        step     = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            step = auto_step ? ~step : manual_step;
            if (rom_req) begin
                if (wait_cnt > 0 && rom_addr !== hold_addr) stable_err++;
                hold_addr = rom_addr;
                if (wait_cnt >= ack_delay) begin
                    rom_ack  = 1'b1;
                    rom_data = mem[rom_addr];
                    acked.push_back(rom_addr);
                    wait_cnt = 0;
                end else begin
                    rom_ack  = 1'b0;
                    rom_data = 4'hE;
                    wait_cnt++;
                end
            end else begin
                if (wait_cnt > 0) stable_err++;
                rom_ack  = 1'b1;
                rom_data = 4'hE;
                wait_cnt = 0;
            end
            ctrl_now = {clear_carry, write_carry, clear_accumulator, write_accumulator,
                        write_register, acc_input_sel, reg_input_sel, alu_op,
                        alu_in0_sel, alu_in1_sel, alu_cin_sel};
            if (ctrl_now[19:15] != 5'b0) begin
                exec_log.push_back(ctrl_now);
                strobe_cnt++;
            end
            if (write_accumulator) begin
                wr_acc_cnt++;
                last_operand = inst_operand;
            end
            if (write_register) wr_reg_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic tb, input logic rz);
        reset       = rst;
        take_branch = tb;
        reg_is_zero = rz;
    endtask

    task automatic loadProgram(input logic [63:0] prog, input int n);
        for (int i = 0; i < 256; i++) mem[i] = 4'h0;
        for (int i = 0; i < n; i++) mem[i] = prog[63-4*i -: 4];
    endtask

    task automatic clearLog();
        acked.delete();
        exec_log.delete();
        wr_acc_cnt = 0;
        wr_reg_cnt = 0;
        strobe_cnt = 0;
        stable_err = 0;
    endtask

    task automatic doReset(input logic tb, input logic rz);
        applyStimulus(1'b1, tb, rz);
        repeat (2) @(negedge clock);
        clearLog();
        reset = 1'b0;
    endtask

    task automatic waitAcks(input string tag, input int n, input int budget);
        int cyc;
        cyc = 0;
        while (acked.size() < n && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
        checkOutput(tag, 32'(acked.size()), 32'(n));
    endtask

    task automatic waitHalt(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (!halted && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
        checkOutput(tag, 32'(halted), 1);
    endtask

    function automatic logic [19:0] expCtrl(input logic [4:0] strb, input logic [2:0] acc,
                                            input logic [1:0] rsel, input logic [2:0] op,
                                            input logic [2:0] in0, input logic [1:0] in1,
                                            input logic [1:0] cin);
        return {strb, acc, rsel, op, in0, in1, cin};
    endfunction

    initial begin
        int cyc;
        int req_cnt;
        logic [7:0] exp_jun [5];

        applyStimulus(1'b1, 1'b0, 1'b0);
        loadProgram(64'h25F0_0000_0000_0000, 4);

        // Reset values, then LDM 5 followed by HLT.
        repeat (3) @(negedge clock);
        checkOutput("rst_rom_req", 32'(rom_req), 0);
        checkOutput("rst_halted", 32'(halted), 0);
        checkOutput("rst_dp_halt", 32'(dp_halt), 0);
        checkOutput("rst_strobes", 32'({clear_carry, write_carry, clear_accumulator,
                                        write_accumulator, write_register}), 0);
        checkOutput("rst_selects", 32'({acc_input_sel, reg_input_sel, alu_op,
                                        alu_in0_sel, alu_in1_sel, alu_cin_sel}), 0);
        checkOutput("rst_operand", 32'(inst_operand), 0);
        checkOutput("rst_pc", 32'(rom_addr), 0);
        clearLog();
        reset = 1'b0;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!write_accumulator && cyc < 40);
        checkOutput("ldm_write_acc", 32'(write_accumulator), 1);
        checkOutput("ldm_acc_sel", 32'(acc_input_sel), 32'(ACC_SEL_IMM));
        checkOutput("ldm_operand", 32'(inst_operand), 5);
        checkOutput("ldm_no_carry_reg", 32'({write_carry, write_register}), 0);
        checkOutput("ldm_rom_req", 32'(rom_req), 0);
        waitHalt("hlt_halted", 60);
        checkOutput("hlt_dp_halt", 32'(dp_halt), 1);
        checkOutput("hlt_pc", 32'(rom_addr), 32'h04);
        req_cnt = 0;
        repeat (6) begin
            @(negedge clock);
            if (rom_req) req_cnt++;
        end
        checkOutput("hlt_no_req", 32'(req_cnt), 0);
        checkOutput("hlt_still_halted", 32'(halted), 1);
        checkOutput("hlt_ack_count", 32'(acked.size()), 4);
        checkOutput("hlt_wr_acc_count", 32'(wr_acc_cnt), 1);

        // JUN 0x10: fetch 0..3 then 0x10, no strobes at all.
        loadProgram(64'h9010_0000_0000_0000, 4);
        doReset(1'b0, 1'b0);
        waitAcks("jun_acks", 5, 80);
        exp_jun = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10};
        for (int i = 0; i < 5; i++) begin
            if (i < acked.size())
                checkOutput($sformatf("jun_addr%0d", i), 32'(acked[i]), 32'(exp_jun[i]));
        end
        checkOutput("jun_no_strobes", 32'(strobe_cnt), 0);

        // JCN taken and not taken.
        loadProgram(64'h1420_0000_0000_0000, 4);
        doReset(1'b1, 1'b0);
        waitAcks("jcn_t_acks", 5, 80);
        if (acked.size() >= 5) checkOutput("jcn_taken_addr", 32'(acked[4]), 32'h20);
        checkOutput("jcn_no_strobes", 32'(strobe_cnt), 0);
        doReset(1'b0, 1'b0);
        waitAcks("jcn_nt_acks", 5, 80);
        if (acked.size() >= 5) checkOutput("jcn_fall_addr", 32'(acked[4]), 32'h04);

        // ISZ r2 target 0x30, register not zero then zero.
        loadProgram(64'h8230_0000_0000_0000, 4);
        doReset(1'b0, 1'b0);
        waitAcks("isz_nz_acks", 5, 80);
        if (acked.size() >= 5) checkOutput("isz_nz_addr", 32'(acked[4]), 32'h30);
        checkOutput("isz_wr_reg_pulses", 32'(wr_reg_cnt), 1);
        checkOutput("isz_strobe_cycles", 32'(strobe_cnt), 1);
        if (exec_log.size() >= 1)
            checkOutput("isz_ctrl", 32'(exec_log[0]),
                        32'(expCtrl(5'b00001, ACC_SEL_ALU, REG_SEL_ALU, ALU_OP_ADD,
                                    ALU0_REG, ALU1_ZERO, CIN_ONE)));
        doReset(1'b0, 1'b1);
        waitAcks("isz_z_acks", 5, 80);
        if (acked.size() >= 5) checkOutput("isz_z_addr", 32'(acked[4]), 32'h04);

        // Decode of the remaining datapath instructions.
        loadProgram(64'h4351_62A0_B074_31F0, 16);
        exp_log[0] = expCtrl(5'b00011, ACC_SEL_REG, REG_SEL_ACC, ALU_OP_ADD, ALU0_ACC, ALU1_REG, CIN_CARRY);
        exp_log[1] = expCtrl(5'b01010, ACC_SEL_ALU, REG_SEL_ALU, ALU_OP_ADD, ALU0_ACC, ALU1_REG, CIN_CARRY);
        exp_log[2] = expCtrl(5'b01010, ACC_SEL_ALU, REG_SEL_ALU, ALU_OP_ADD, ALU0_ACC, ALU1_NREG, CIN_NCARRY);
        exp_log[3] = expCtrl(5'b10100, ACC_SEL_ALU, REG_SEL_ALU, ALU_OP_ADD, ALU0_ACC, ALU1_REG, CIN_CARRY);
        exp_log[4] = expCtrl(5'b10000, ACC_SEL_ALU, REG_SEL_ALU, ALU_OP_ADD, ALU0_ACC, ALU1_REG, CIN_CARRY);
        exp_log[5] = expCtrl(5'b00001, ACC_SEL_ALU, REG_SEL_ALU, ALU_OP_ADD, ALU0_REG, ALU1_ZERO, CIN_ONE);
        exp_log[6] = expCtrl(5'b00010, ACC_SEL_REG, REG_SEL_ALU, ALU_OP_ADD, ALU0_ACC, ALU1_REG, CIN_CARRY);
        doReset(1'b0, 1'b0);
        waitHalt("dec_halted", 200);
        checkOutput("dec_exec_count", 32'(exec_log.size()), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < exec_log.size())
                checkOutput($sformatf("dec_ctrl%0d", i), 32'(exec_log[i]), 32'(exp_log[i]));
        end
        checkOutput("dec_pc", 32'(rom_addr), 32'h10);

        // Slow ROM: request held stable, one pc step per ack, reset in FETCH_AL.
        ack_delay = 3;
        loadProgram(64'h9010_0000_0000_0000, 4);
        doReset(1'b0, 1'b0);
        waitAcks("slow_acks", 3, 60);
        checkOutput("slow_stable", 32'(stable_err), 0);
        if (acked.size() >= 3) checkOutput("slow_ah_addr", 32'(acked[2]), 32'h02);
        checkOutput("slow_pc_in_al", 32'(rom_addr), 32'h03);
        reset = 1'b1;
        #1;
        checkOutput("slow_rst_req", 32'(rom_req), 0);
        @(negedge clock);
        checkOutput("slow_rst_pc", 32'(rom_addr), 32'h00);
        checkOutput("slow_rst_strobes", 32'(strobe_cnt), 0);
        clearLog();
        reset = 1'b0;
        waitAcks("slow_rerun_acks", 5, 120);
        if (acked.size() >= 5) begin
            checkOutput("slow_rerun_first", 32'(acked[0]), 32'h00);
            checkOutput("slow_rerun_jump", 32'(acked[4]), 32'h10);
        end
        checkOutput("slow_rerun_stable", 32'(stable_err), 0);
        checkOutput("slow_rerun_strobes", 32'(strobe_cnt), 0);
        ack_delay = 0;

`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
        // Single-step: park after each EXEC, one instruction per step rise.
        auto_step   = 1'b0;
        manual_step = 1'b0;
        loadProgram(64'h2122_0000_0000_0000, 4);
        doReset(1'b0, 1'b0);
        cyc = 0;
        while (wr_acc_cnt < 1 && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        checkOutput("step_first_exec", 32'(wr_acc_cnt), 1);
        req_cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (rom_req) req_cnt++;
        end
        checkOutput("step_parked_req", 32'(req_cnt), 0);
        checkOutput("step_parked_dp_halt", 32'(dp_halt), 1);
        manual_step = 1'b1;
        repeat (10) @(negedge clock);
        checkOutput("step_one_more", 32'(wr_acc_cnt), 2);
        checkOutput("step_operand", 32'(last_operand), 2);
        checkOutput("step_acks", 32'(acked.size()), 4);
        manual_step = 1'b0;
        repeat (6) @(negedge clock);
        checkOutput("step_no_extra", 32'(wr_acc_cnt), 2);
        auto_step = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
